cache_arbiter: RTL and testbench

CACHE_ARBITER -- requirements
Module: cache_arbiter

---
 rtl/rv32i_types.sv | 19 +
 rtl/cache_arbiter.sv | 104 ++++++++++
 tb/tb_cache_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared types for the cache/L2 arbitration path.
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RECOVER = 2'd3
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

endpackage

// File: rtl/cache_arbiter.sv
// Round-robin arbiter of I-side and D-side line requests onto one L2 port.
// Grant latency 1 cycle; one cycle of RECOVER after each completion; no abort.
import rv32i_types::*;

module cache_arbiter (
  input  logic              clk,
  input  logic              rst,
  input  logic              icache_read,
  input  logic [ADDR_W-1:0] icache_address,
  output logic [LINE_W-1:0] icache_rdata,
  output logic              icache_resp,
  input  logic              dcache_read,
  input  logic              dcache_write,
  input  logic [ADDR_W-1:0] dcache_address,
  input  logic [LINE_W-1:0] dcache_wdata,
  output logic [LINE_W-1:0] dcache_rdata,
  output logic              dcache_resp,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_address,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp
);

  arb_state_t state, state_next;
  grant_t     last_grant, last_grant_next;
  logic       d_req;
  logic       load_i, load_d, done;

  assign d_req        = dcache_read | dcache_write;
  assign icache_rdata = l2_rdata;
  assign dcache_rdata = l2_rdata;

  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    load_i          = 1'b0;
    load_d          = 1'b0;
    done            = 1'b0;
    icache_resp     = 1'b0;
    dcache_resp     = 1'b0;
    case (state)
      IDLE: begin
        // On a tie the side that did not win last time goes first.
        if (icache_read && (!d_req || last_grant == GRANT_D)) begin
          state_next      = SERVE_I;
          last_grant_next = GRANT_I;
          load_i          = 1'b1;
        end else if (d_req) begin
          state_next      = SERVE_D;
          last_grant_next = GRANT_D;
          load_d          = 1'b1;
        end
      end
      SERVE_I: begin
        if (l2_resp) begin
          state_next  = RECOVER;
          done        = 1'b1;
          icache_resp = rst;
        end
      end
      SERVE_D: begin
        if (l2_resp) begin
          state_next  = RECOVER;
          done        = 1'b1;
          dcache_resp = rst;
        end
      end
      RECOVER: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= GRANT_D;
      l2_read    <= 1'b0;
      l2_write   <= 1'b0;
      l2_address <= '0;
      l2_wdata   <= '0;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
      if (load_i) begin
        l2_address <= icache_address;
        l2_wdata   <= '0;
        l2_read    <= 1'b1;
        l2_write   <= 1'b0;
      end else if (load_d) begin
        // Read and write together is a write.
        l2_address <= dcache_address;
        l2_wdata   <= dcache_wdata;
        l2_read    <= ~dcache_write;
        l2_write   <= dcache_write;
      end else if (done) begin
        l2_read  <= 1'b0;
        l2_write <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench: bench-side model predicts grant order, a behavioural L2 answers requests.
module tb_cache_arbiter;
  import rv32i_types::*;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         icache_read = 1'b0;
  logic [31:0]  icache_address = '0;
  logic [255:0] icache_rdata;
  logic         icache_resp;
  logic         dcache_read = 1'b0;
  logic         dcache_write = 1'b0;
  logic [31:0]  dcache_address = '0;
  logic [255:0] dcache_wdata = '0;
  logic [255:0] dcache_rdata;
  logic         dcache_resp;
  logic         l2_read, l2_write;
  logic [31:0]  l2_address;
  logic [255:0] l2_wdata;
  logic [255:0] l2_rdata = '0;
  logic         l2_resp = 1'b0;

  cache_arbiter dut (
    .clk(clk), .rst(rst),
    .icache_read(icache_read), .icache_address(icache_address),
    .icache_rdata(icache_rdata), .icache_resp(icache_resp),
    .dcache_read(dcache_read), .dcache_write(dcache_write),
    .dcache_address(dcache_address), .dcache_wdata(dcache_wdata),
    .dcache_rdata(dcache_rdata), .dcache_resp(dcache_resp),
    .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address),
    .l2_wdata(l2_wdata), .l2_rdata(l2_rdata), .l2_resp(l2_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         side;   // 0 = I, 1 = D
    bit         wr;
    bit [31:0]  addr;
    bit [255:0] wdata;
  } txn_t;

  typedef struct {
    bit         side;
    bit [255:0] rdata;
  } rsp_t;

  txn_t exp_grant[$];
  rsp_t exp_rsp[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   got_resp[2];
  bit   in_service[2];
  int   last_req_cyc[2];
  int   last_resp_cyc[2];
  bit   l2_auto = 1'b1;
  int   fixed_delay = -1;
  bit   model_last = 1'b1;   // side granted last; reset leaves D

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural L2: takes each new request, checks it against the predicted
  // grant, keeps checking it is held steady, then answers after a delay.
  initial begin
    txn_t t;
    int   n;
    bit [255:0] rd;
    forever begin
      @(negedge clk);
      if (l2_auto && rst && (l2_read || l2_write)) begin
        if (exp_grant.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL l2_unexpected_request: addr %0h with none pending", l2_address);
          t.side = 1'b0; t.wr = l2_write; t.addr = l2_address; t.wdata = l2_wdata;
        end else begin
          t = exp_grant.pop_front();
          chk("l2_address", l2_address, t.addr);
          chk("l2_write", l2_write, t.wr);
          chk("l2_read", l2_read, !t.wr);
          if (t.wr) chk("l2_wdata", l2_wdata, t.wdata);
        end
        last_req_cyc[t.side] = cyc;
        in_service[t.side]   = 1'b1;
        n = (fixed_delay >= 0) ? fixed_delay : $urandom_range(0, 4);
        for (int k = 0; k <= n; k++) begin
          if (k < n) @(negedge clk);
          else begin
            @(posedge clk); #1;
            for (int j = 0; j < 8; j++) rd[j*32 +: 32] = $urandom;
            l2_rdata = rd;
            l2_resp  = 1'b1;
            exp_rsp.push_back('{side: t.side, rdata: rd});
            @(negedge clk);
          end
          chk("l2_address_stable", l2_address, t.addr);
          chk("l2_op_stable", {l2_read, l2_write}, {!t.wr, t.wr});
          if (t.wr) chk("l2_wdata_stable", l2_wdata, t.wdata);
        end
        @(posedge clk); #1;
        l2_resp = 1'b0;
      end
    end
  end

  // Response monitor.
  initial begin
    rsp_t r;
    forever begin
      @(negedge clk);
      chk("icache_rdata", icache_rdata, l2_rdata);
      chk("dcache_rdata", dcache_rdata, l2_rdata);
      if (icache_resp && dcache_resp) begin
        n_cmp++; n_fail++;
        $display("FAIL both_resp: got 1/1 expected at most one");
      end
      for (int s = 0; s < 2; s++) begin
        if ((s == 0) ? icache_resp : dcache_resp) begin
          if (exp_rsp.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL resp_unexpected: got resp on side %0d expected none", s);
          end else begin
            r = exp_rsp.pop_front();
            chk("resp_side", s, r.side);
            chk("resp_rdata", (s == 0) ? icache_rdata : dcache_rdata, r.rdata);
          end
          got_resp[s]      = 1'b1;
          in_service[s]    = 1'b0;
          last_resp_cyc[s] = cyc;
        end
      end
    end
  end

  task automatic drive(input bit side, input bit rd, input bit wr, input bit [31:0] a, input bit [255:0] wd);
    if (side == 1'b0) begin
      icache_read = rd; icache_address = a;
    end else begin
      dcache_read = rd; dcache_write = wr; dcache_address = a; dcache_wdata = wd;
    end
  endtask

  task automatic requester(input bit side, input bit rd, input bit wr, input bit [31:0] a,
                           input bit [255:0] wd, input bit hold_extra, input bit mutate, input bit drop);
    bit r = rd, w = wr;
    bit [31:0]  ca = a;
    bit [255:0] cw = wd;
    int budget = 0;
    got_resp[side] = 1'b0;
    drive(side, r, w, ca, cw);
    while (!got_resp[side] && budget < 200) begin
      @(posedge clk); #1;
      budget++;
      if (!got_resp[side] && in_service[side]) begin
        if (mutate) begin
          ca = $urandom;
          cw[31:0] = $urandom;
        end
        if (drop) begin
          r = 1'b0; w = 1'b0;
        end
        drive(side, r, w, ca, cw);
      end
    end
    if (!got_resp[side]) begin
      n_cmp++; n_fail++;
      $display("FAIL resp_timeout: got no resp on side %0d expected one", side);
    end
    if (hold_extra) begin
      @(posedge clk); #1;
    end
    drive(side, 1'b0, 1'b0, ca, cw);
  endtask

  // Model: a tie goes to the side not granted last; each grant updates it.
  task automatic round(input bit do_i, input bit do_d, input bit [31:0] ia, input bit d_rd, input bit d_wr,
                       input bit [31:0] da, input bit [255:0] dw, input bit hold_i, input bit hold_d,
                       input bit mut, input bit drop);
    txn_t ti, td;
    ti.side = 1'b0; ti.wr = 1'b0; ti.addr = ia; ti.wdata = '0;
    td.side = 1'b1; td.wr = d_wr; td.addr = da; td.wdata = dw;
    if (do_i && do_d) begin
      if (model_last) begin
        exp_grant.push_back(ti); exp_grant.push_back(td); model_last = 1'b1;
      end else begin
        exp_grant.push_back(td); exp_grant.push_back(ti); model_last = 1'b0;
      end
    end else if (do_i) begin
      exp_grant.push_back(ti); model_last = 1'b0;
    end else if (do_d) begin
      exp_grant.push_back(td); model_last = 1'b1;
    end
    fork
      begin if (do_i) requester(1'b0, 1'b1, 1'b0, ia, '0, hold_i, mut, drop); end
      begin if (do_d) requester(1'b1, d_rd, d_wr, da, dw, hold_d, mut, drop); end
    join
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
  endtask

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    summary();
    $finish;
  end

  initial begin
    bit [255:0] a5;
    int p, op;
    for (int j = 0; j < 32; j++) a5[j*8 +: 8] = 8'hA5;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_l2_read", l2_read, 1'b0);
    chk("rst_l2_write", l2_write, 1'b0);
    chk("rst_l2_address", l2_address, 32'h0);
    chk("rst_l2_wdata", l2_wdata, 256'h0);
    chk("rst_icache_resp", icache_resp, 1'b0);
    chk("rst_dcache_resp", dcache_resp, 1'b0);
    chk("rst_state", dut.state, IDLE);
    @(posedge clk); #1;
    rst = 1'b1;

    // Lone I read with a 5-cycle L2 latency.
    fixed_delay = 4;
    fork
      round(1'b1, 1'b0, 32'h0000_1000, 1'b0, 1'b0, 32'h0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      begin
        @(negedge clk);
        chk("i_lat_before", l2_read, 1'b0);
        @(negedge clk);
        chk("i_lat_read", l2_read, 1'b1);
        chk("i_lat_addr", l2_address, 32'h0000_1000);
      end
    join
    chk("i_resp_delay", last_resp_cyc[0] - last_req_cyc[0], 5);
    fixed_delay = -1;

    // Reset, then a tie: I first, D write follows 2 cycles after icache_resp ends.
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    model_last = 1'b1;
    round(1'b1, 1'b1, 32'h0000_2000, 1'b0, 1'b1, 32'h8000_0040, a5, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("tie_d_gap", last_req_cyc[1] - last_resp_cyc[0], 3);
    chk("tie_i_first", last_resp_cyc[0] < last_req_cyc[1], 1'b1);

    // Back-to-back ties alternate; holding a read past resp must not re-issue.
    round(1'b1, 1'b1, 32'h0000_3000, 1'b1, 1'b0, 32'h0000_4000, '0, 1'b1, 1'b1, 1'b1, 1'b0);
    round(1'b1, 1'b1, 32'h0000_5000, 1'b1, 1'b1, 32'h0000_6000, a5, 1'b1, 1'b0, 1'b0, 1'b0);

    // Random traffic.
    for (int i = 0; i < 40; i++) begin
      p  = $urandom_range(0, 2);
      op = $urandom_range(0, 2);
      round(p != 1, p != 0, $urandom, op != 1, op != 0, $urandom,
            {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    // Reset in SERVE_D while L2 answers: no resp, everything cleared.
    l2_auto = 1'b0;
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b1, 32'h0000_7700, a5);
    @(negedge clk);
    @(negedge clk);
    chk("rstmid_l2_write", l2_write, 1'b1);
    @(posedge clk); #1;
    dcache_address = 32'h0000_9900;
    rst = 1'b0;
    l2_resp = 1'b1;
    @(negedge clk);
    chk("rstmid_addr_held", l2_address, 32'h0000_7700);
    chk("rstmid_no_dresp", dcache_resp, 1'b0);
    chk("rstmid_no_iresp", icache_resp, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    l2_resp = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 32'h0, '0);
    @(negedge clk);
    chk("rstmid_l2_write_clr", l2_write, 1'b0);
    chk("rstmid_l2_read_clr", l2_read, 1'b0);
    chk("rstmid_l2_address_clr", l2_address, 32'h0);
    chk("rstmid_l2_wdata_clr", l2_wdata, 256'h0);
    chk("rstmid_dcache_resp", dcache_resp, 1'b0);
    chk("rstmid_state", dut.state, IDLE);
    model_last = 1'b1;
    l2_auto = 1'b1;
    @(posedge clk); #1;

    // After reset the first tie goes to I again.
    round(1'b1, 1'b1, 32'h0000_A000, 1'b1, 1'b0, 32'h0000_B000, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_rst_tie_i_first", last_resp_cyc[0] < last_req_cyc[1], 1'b1);

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("grant_queue_empty", exp_grant.size(), 0);
    chk("resp_queue_empty", exp_rsp.size(), 0);
    summary();
    $finish;
  end

endmodule
